// File: rtl/alu_res_serializer.sv
// Buffers ALU results in a small FIFO and streams each one out as bytes, LSB first,
// over a valid/ready link towards the UART TX framer. Results that find the FIFO full are dropped.
module alu_res_serializer #(
  parameter int BUSR  = 16,
  parameter int DEPTH = 4,
  parameter int LVLW  = $clog2(DEPTH) + 1
) (
  input  logic            i_clk,
  input  logic            i_arst,
  input  logic            i_res_valid,
  input  logic [BUSR-1:0] i_res,
  input  logic            i_clr_ovf,
  output logic [7:0]      o_tx_data,
  output logic            o_tx_valid,
  input  logic            i_tx_ready,
  output logic [LVLW-1:0] o_level,
  output logic            o_overflow,
  output logic            o_busy,
  output logic            o_dbg_state
);

  localparam int NBYTES = BUSR / 8;
  localparam int PW     = $clog2(DEPTH);
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Handshake: a byte transfers on a rising edge where o_tx_valid and i_tx_ready are
  // both high; once raised, o_tx_valid and o_tx_data hold until that transfer happens.

  state_t            state_q, state_d;
  logic              arm_q, arm_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [BUSR-1:0]   shift_q, shift_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVLW-1:0]   level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              pop, push, drop, hs, last_byte;
  logic [BUSR-1:0]   mem_q [DEPTH];

  always_comb begin
    state_d   = state_q;
    arm_d     = arm_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    valid_d   = valid_q;
    pop       = 1'b0;
    hs        = valid_q && i_tx_ready;
    last_byte = (idx_q == IW'(NBYTES - 1));

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        // From idle, a non-empty FIFO is acknowledged one cycle before the head is popped.
        if (level_q != '0) begin
          if (arm_q) begin
            pop     = 1'b1;
            arm_d   = 1'b0;
            state_d = SEND;
            valid_d = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            idx_d   = '0;
          end else begin
            arm_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (hs) begin
          if (!last_byte) begin
            shift_d = shift_q >> 8;
            idx_d   = idx_q + IW'(1);
          end else if (level_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            idx_d   = '0;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    push     = i_res_valid && ((level_q != LVLW'(DEPTH)) || pop);
    drop     = i_res_valid && !push;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    case ({push, pop})
      2'b10:   level_d = level_q + LVLW'(1);
      2'b01:   level_d = level_q - LVLW'(1);
      default: level_d = level_q;
    endcase

    if (drop)           ovf_d = 1'b1;
    else if (i_clr_ovf) ovf_d = 1'b0;
    else                ovf_d = ovf_q;

    busy_d = (state_d != IDLE) || (level_d != '0);
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q  <= IDLE;
      arm_q    <= 1'b0;
      idx_q    <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      arm_q    <= arm_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  // Storage needs no reset: the pointers and level decide what is live.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_res;
  end

  assign o_tx_data   = shift_q[7:0];
  assign o_tx_valid  = valid_q;
  assign o_level     = level_q;
  assign o_overflow  = ovf_q;
  assign o_busy      = busy_q;
  assign o_dbg_state = state_q;

endmodule

// File: doc/alu_res_serializer.md
Name: alu_res_serializer

Overview:
- Downstream stage of the ALU: captures each valid BUSR-bit ALU result into a small FIFO.
- Each buffered result is emitted as NBYTES = BUSR/8 bytes, LSB byte first, over a valid/ready byte stream feeding the UART TX framer.
- The ALU has no backpressure, so results are absorbed here. If the FIFO cannot accept a result, the result is dropped and a sticky overflow flag is set.

Parameters:
- BUSR, 16, ALU result width; must be a multiple of 8 (NBYTES = BUSR/8 ≥ 1).
- DEPTH, 4, FIFO depth in results; power of two, ≥ 2.
- LVLW, $clog2(DEPTH)+1, width of the level output.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_arst  in  1  asynchronous, active-high reset.
- i_res_valid  in  1  ALU o_valid; one result per cycle while high.
- i_res  in  BUSR  ALU o_alu_res.
- i_clr_ovf  in  1  synchronous clear of o_overflow.
- o_tx_data  out  8  current byte to TX.
- o_tx_valid  out  1  o_tx_data is valid.
- i_tx_ready  in  1  TX accepts the byte this cycle.
- o_level  out  LVLW  FIFO occupancy (entries not yet loaded into the shifter).
- o_overflow  out  1  sticky: a result was dropped.
- o_busy  out  1  FSM not in IDLE, or FIFO non-empty.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (i_clk, i_arst).
  - i_arst asserted: FIFO pointers = 0, o_level = 0, o_tx_valid = 0, o_tx_data = 0, o_overflow = 0, o_busy = 0, FSM = IDLE, byte index = 0, shifter = 0.
  - Reset mid-transfer aborts it; bytes and FIFO contents are lost.
- FIFO write:
  - Occurs when i_res_valid=1 and (level < DEPTH, or a pop occurs in the same cycle).
  - i_res_valid=1 with level == DEPTH and no same-cycle pop: result dropped, o_overflow <= 1.
- o_overflow:
  - Cleared by i_clr_ovf.
  - If set and clear land in the same cycle, set wins.
- Pointers: wrap modulo DEPTH. o_level updates on the cycle after a push or pop; a simultaneous push and pop leaves it unchanged.
- FSM states:
  - IDLE:
    - o_tx_valid = 0.
    - If level > 0: pop head into shifter, index = 0, go to SEND.
  - SEND:
    - o_tx_valid = 1, o_tx_data = shifter[7:0].
    - Data and valid held stable until i_tx_ready=1. Valid is never deasserted without a handshake.
    - On a handshake with index < NBYTES-1: shifter >>= 8, index++.
    - On a handshake with index == NBYTES-1:
      - If level > 0: pop the next head into the shifter, index = 0, stay in SEND. Back-to-back, no bubble.
      - Otherwise go to IDLE (o_tx_valid = 0 the next cycle).
- Latency: result sampled at edge k into an empty, idle block → o_tx_valid high after edge k+2 with the LSB byte.
- Throughput: with i_tx_ready held high, one byte per cycle and no gaps between results.
- i_tx_ready is ignored while o_tx_valid = 0.
- o_busy = (FSM != IDLE) | (level != 0); registered outputs only.
- Only data path: result bits are passed unmodified; no arithmetic beyond pointer and index increments.

Test Plan:
- Single result 16'hA55A, i_tx_ready=1 → bytes 8'h5A then 8'hA5 on consecutive cycles; o_tx_valid first high 2 edges after capture; o_busy falls after the last byte.
- Backpressure: result 16'h1234 with i_tx_ready low for 5 cycles, then pulsed → o_tx_data held at 8'h34 with valid high throughout; 8'h12 follows; no byte duplicated or lost.
- Burst of 4 results 0x0001..0x0004 on consecutive cycles, i_tx_ready=1 → byte stream 01,00,02,00,03,00,04,00 with no gaps; o_level peaks and drains to 0.
- Overflow: i_tx_ready=0, 6 consecutive results → the first loads into the shifter, the next 4 fill the FIFO (o_level=4), the 6th is dropped with o_overflow=1. After draining, exactly 5 results are emitted; i_clr_ovf clears the flag.
- Simultaneous pop and push at full: a new result arrives on the same cycle the last byte of the current result handshakes → both accepted; o_level stays 4; o_overflow stays 0.
- i_arst asserted mid-SEND after 1 byte → all outputs return to reset values asynchronously; after release, a new result 16'hBEEF emits 8'hEF, 8'hBE only.
